// File: rtl/simmem_pkg.sv
// Shared types and sizes for the simulated-memory release enabler.
// The slot record is sized from the Def* constants here. Change the widths
// here, not only on the top-level parameters, so that both stay in step.
package simmem_pkg;

  localparam int DefIdWidth    = 8;
  localparam int DefNumSlots   = 16;
  localparam int DefDelayWidth = 8;

  localparam int SlotIdxWidth  = $clog2(DefNumSlots);
  localparam int NumIds        = 2 ** DefIdWidth;
  localparam int OutstWidth    = $clog2(DefNumSlots + 1);

  localparam logic [DefDelayWidth-1:0] DelayOne = DefDelayWidth'(1);
  localparam logic [SlotIdxWidth-1:0]  RankOne  = SlotIdxWidth'(1);
  localparam logic [OutstWidth-1:0]    OutstOne = OutstWidth'(1);

  // One delayed request: rank is its position in its ID queue (0 = oldest).
  typedef struct packed {
    logic                     valid;
    logic [DefIdWidth-1:0]    id;
    logic [DefDelayWidth-1:0] counter;
    logic [SlotIdxWidth-1:0]  rank;
  } release_slot_t;

endpackage

// File: rtl/simmem_delay_slot.sv
// One outstanding delayed request. It counts its delay down, saturating at 0,
// moves up its ID queue when an older request of the same ID leaves, and is
// freed when it is the one released. Allocation happens only while the slot
// is free, so it never coincides with the slot's own countdown or release.
module simmem_delay_slot
  import simmem_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     alloc_i,
  input  logic [DefIdWidth-1:0]    alloc_id_i,
  input  logic [DefDelayWidth-1:0] alloc_delay_i,
  input  logic [SlotIdxWidth-1:0]  alloc_rank_i,
  input  logic                     rel_fire_i,
  input  logic [DefIdWidth-1:0]    rel_id_i,
  output release_slot_t            slot_o,
  output logic                     matured_o
);

  release_slot_t slot_q, slot_d;

  // Next-state: countdown, rank shift or free on release, then load on allocate.
  always_comb begin
    slot_d = slot_q;
    if (slot_q.valid) begin
      if (slot_q.counter != '0) begin
        slot_d.counter = slot_q.counter - DelayOne;
      end
      if (rel_fire_i && (slot_q.id == rel_id_i)) begin
        if (slot_q.rank == '0) begin
          slot_d.valid = 1'b0;
        end else begin
          slot_d.rank = slot_q.rank - RankOne;
        end
      end
    end
    if (alloc_i) begin
      slot_d.valid   = 1'b1;
      slot_d.id      = alloc_id_i;
      slot_d.counter = alloc_delay_i;
      slot_d.rank    = alloc_rank_i;
    end
  end

  // Slot register, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o    = slot_q;
  assign matured_o = slot_q.valid && (slot_q.rank == '0) && (slot_q.counter == '0);

endmodule

// File: rtl/simmem_release_enabler.sv
// Per-ID release scheduler for the simulated memory response path.
// Handshake: a request is taken on a cycle where req_valid_i && req_ready_o;
// the requester keeps req_valid_i and its payload stable until then.
// A release (released_valid_i) takes effect only when release_en_o is high for
// released_id_i. Any other release is a protocol violation and is ignored.
// Optional SVA checks are compiled in with SIMMEM_RELEASE_ENABLER_ASSERT_EN.
module simmem_release_enabler
  import simmem_pkg::*;
#(
  parameter int IDWidth    = DefIdWidth,
  parameter int NumSlots   = DefNumSlots,
  parameter int DelayWidth = DefDelayWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [IDWidth-1:0]    req_id_i,
  input  logic [DelayWidth-1:0] req_delay_i,
  output logic [2**IDWidth-1:0] release_en_o,
  input  logic                  released_valid_i,
  input  logic [IDWidth-1:0]    released_id_i
);

  release_slot_t               slots   [NumSlots];
  logic [NumSlots-1:0]         matured;
  logic [NumSlots-1:0]         free;
  logic [NumSlots-1:0]         alloc;
  logic                        accept;
  logic                        rel_fire;
  logic [SlotIdxWidth-1:0]     alloc_rank;
  logic [OutstWidth-1:0]       outstanding_q [NumIds];
  logic [OutstWidth-1:0]       outstanding_d [NumIds];

  for (genvar s = 0; s < NumSlots; s++) begin : g_slot
    simmem_delay_slot u_slot (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .alloc_i       (alloc[s]),
      .alloc_id_i    (req_id_i),
      .alloc_delay_i (req_delay_i),
      .alloc_rank_i  (alloc_rank),
      .rel_fire_i    (rel_fire),
      .rel_id_i      (released_id_i),
      .slot_o        (slots[s]),
      .matured_o     (matured[s])
    );
    assign free[s] = !slots[s].valid;
  end

  assign req_ready_o = |free;
  assign accept      = req_valid_i && req_ready_o;
  assign rel_fire    = released_valid_i && release_en_o[released_id_i];

  // A same-cycle release of the same ID moves the new request one place up.
  assign alloc_rank = SlotIdxWidth'(outstanding_q[req_id_i]
                      - ((rel_fire && (released_id_i == req_id_i)) ? OutstOne : '0));

  // Lowest-index free slot takes the accepted request.
  always_comb begin
    logic found;
    alloc = '0;
    found = 1'b0;
    for (int s = 0; s < NumSlots; s++) begin
      if (free[s] && !found) begin
        alloc[s] = accept;
        found    = 1'b1;
      end
    end
  end

  // OR each matured rank-0 slot onto its ID's release line.
  always_comb begin
    release_en_o = '0;
    for (int s = 0; s < NumSlots; s++) begin
      if (matured[s]) begin
        release_en_o[slots[s].id] = 1'b1;
      end
    end
  end

  // Per-ID queue depth: +1 on accept, -1 on release; same ID cancels out.
  always_comb begin
    outstanding_d = outstanding_q;
    if (accept) begin
      outstanding_d[req_id_i] = outstanding_d[req_id_i] + OutstOne;
    end
    if (rel_fire) begin
      outstanding_d[released_id_i] = outstanding_d[released_id_i] - OutstOne;
    end
  end

  // Outstanding counters, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumIds; i++) begin
        outstanding_q[i] <= '0;
      end
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

`ifdef SIMMEM_RELEASE_ENABLER_ASSERT_EN
  a_rel_needs_en : assert property (@(posedge clk_i) disable iff (!rst_ni)
    released_valid_i |-> release_en_o[released_id_i]);

  a_req_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (req_valid_i && !req_ready_o) |=> req_valid_i);

  for (genvar i = 0; i < NumIds; i++) begin : g_outst_chk
    a_outst_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
      int'(outstanding_q[i]) <= NumSlots);
  end

  for (genvar a = 0; a < NumSlots; a++) begin : g_rank_a
    for (genvar b = a + 1; b < NumSlots; b++) begin : g_rank_b
      a_one_head : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(slots[a].valid && slots[b].valid && (slots[a].id == slots[b].id)
          && (slots[a].rank == '0) && (slots[b].rank == '0)));
    end
  end
`endif

endmodule

// File: tb/tb_simmem_release_enabler.sv
// Bench for simmem_release_enabler: directed scenarios plus a random phase,
// checked every cycle against an in-order pending list with absolute
// maturity times.
module tb_simmem_release_enabler;

  // ---------------- clock / reset ----------------
  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         req_valid_i;
  logic         req_ready_o;
  logic [7:0]   req_id_i;
  logic [7:0]   req_delay_i;
  logic [255:0] release_en_o;
  logic         released_valid_i;
  logic [7:0]   released_id_i;

  always #5 clk_i = ~clk_i;

  simmem_release_enabler dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_id_i         (req_id_i),
    .req_delay_i      (req_delay_i),
    .release_en_o     (release_en_o),
    .released_valid_i (released_valid_i),
    .released_id_i    (released_id_i)
  );

  // ---------------- reference model ----------------
  // Pending requests in acceptance order; each matures at an absolute edge count.
  typedef struct {
    logic [7:0] id;
    int         mature;
  } ent_t;

  ent_t mq[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  // The oldest pending request of each ID is enabled once its time is reached.
  function automatic logic [255:0] model_en();
    logic [255:0] seen;
    logic [255:0] en;
    seen = '0;
    en   = '0;
    foreach (mq[k]) begin
      if (!seen[mq[k].id]) begin
        seen[mq[k].id] = 1'b1;
        if (mq[k].mature <= cyc) en[mq[k].id] = 1'b1;
      end
    end
    return en;
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1: drive, check outputs, clock, update the model.
  task automatic step(input bit v, input int id, input int d, input bit rv, input int rid);
    logic [255:0] een;
    logic [7:0]   rid8;
    bit           eready;
    bit           acc;
    bit           rel;
    int           idx;
    ent_t         e;
    rid8             = 8'(rid);
    req_valid_i      = v;
    req_id_i         = 8'(id);
    req_delay_i      = 8'(d);
    released_valid_i = rv;
    released_id_i    = rid8;
    #1;
    een    = model_en();
    eready = (mq.size() < 16);
    checks++;
    assert (release_en_o === een) else begin
      failures++;
      $error("FAIL release_en cyc=%0d observed=%h expected=%h", cyc, release_en_o, een);
    end
    checks++;
    assert (req_ready_o === eready) else begin
      failures++;
      $error("FAIL req_ready cyc=%0d observed=%b expected=%b", cyc, req_ready_o, eready);
    end
    acc = v && eready;
    rel = rv && een[rid8];
    @(posedge clk_i);
    cyc++;
    if (rel) begin
      idx = -1;
      foreach (mq[k]) if (idx < 0 && mq[k].id == rid8) idx = k;
      mq.delete(idx);
    end
    if (acc) begin
      e.id     = 8'(id);
      e.mature = cyc + d;
      mq.push_back(e);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic rel(input int id);
    step(0, 0, 0, 1, id);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic mid_reset();
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    assert (release_en_o === '0) else begin
      failures++;
      $error("FAIL reset_en observed=%h expected=0", release_en_o);
    end
    checks++;
    assert (req_ready_o === 1'b1) else begin
      failures++;
      $error("FAIL reset_ready observed=%b expected=1", req_ready_o);
    end
    mq.delete();
    repeat (2) begin
      @(posedge clk_i);
      cyc++;
    end
    #1;
    rst_ni = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_ni           = 1'b0;
    req_valid_i      = 1'b0;
    req_id_i         = '0;
    req_delay_i      = '0;
    released_valid_i = 1'b0;
    released_id_i    = '0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    assert (release_en_o === '0 && req_ready_o === 1'b1) else begin
      failures++;
      $error("FAIL in_reset observed en=%h ready=%b expected en=0 ready=1", release_en_o, req_ready_o);
    end
    rst_ni = 1'b1;
    idle(3);

    // ID 3, delay 4: rises 5 cycles after acceptance, falls after release.
    step(1, 3, 4, 0, 0);
    idle(6);
    rel(3);
    idle(2);

    // ID 5 delay 10 then delay 0: younger waits, then no gap after release.
    step(1, 5, 10, 0, 0);
    step(1, 5, 0, 0, 0);
    idle(11);
    rel(5);
    idle(2);
    rel(5);
    idle(2);

    // Same-cycle request and release on ID 7 with one outstanding.
    step(1, 7, 0, 0, 0);
    idle(2);
    step(1, 7, 3, 1, 7);
    step(1, 7, 0, 0, 0);
    idle(5);
    rel(7);
    idle(1);
    rel(7);
    idle(2);

    // Delay 0 on IDs 1 and 2 back to back; release 2 first.
    step(1, 1, 0, 0, 0);
    step(1, 2, 0, 0, 0);
    idle(2);
    rel(2);
    idle(2);
    rel(1);
    idle(2);

    // Release for an ID that is not enabled is ignored.
    step(1, 9, 6, 0, 0);
    rel(9);
    rel(10);
    idle(6);
    rel(9);
    idle(1);

    // Fill all 16 slots, refuse a 17th, free one and refill.
    for (int i = 0; i < 15; i++) step(1, 20 + i, 255, 0, 0);
    step(1, 40, 0, 0, 0);
    step(1, 41, 0, 0, 0);
    rel(40);
    idle(1);
    step(1, 42, 255, 0, 0);
    idle(2);

    // Reset with all slots in flight; nothing stale afterwards.
    mid_reset();
    idle(4);
    step(1, 4, 2, 0, 0);
    step(1, 6, 5, 0, 0);
    step(1, 8, 1, 0, 0);
    step(1, 4, 0, 0, 0);
    idle(1);
    mid_reset();
    idle(8);

    // Random traffic over a few IDs to force queueing and collisions.
    for (int n = 0; n < 500; n++) begin
      step($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 12),
           $urandom_range(0, 2) != 0, $urandom_range(0, 7));
    end

    // Drain: release whatever is enabled until the model is empty.
    for (int n = 0; n < 200 && mq.size() != 0; n++) begin
      logic [255:0] een;
      int           pick;
      een  = model_en();
      pick = -1;
      for (int i = 0; i < 8; i++) if (pick < 0 && een[i]) pick = i;
      if (pick >= 0) rel(pick);
      else idle(1);
    end
    checks++;
    assert (mq.size() == 0) else begin
      failures++;
      $error("FAIL drain observed pending=%0d expected=0", mq.size());
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simmem_release_enabler.md
# simmem_release_enabler

Per-ID release scheduler for the simulated memory controller's response path. It accepts each incoming request's AXI ID and programmed delay, counts the delay down in a slot, and drives the one-hot-per-ID `release_en` vector consumed by `simmem_linkedlist_bank`. Responses within one ID are released strictly in request order. Each slot is freed when the bank reports the corresponding response handshake.

## Interface
Parameters:
- `IDWidth`, 8: width of the AXI ID; `2**IDWidth` release lines.
- `NumSlots`, 16: maximum number of outstanding delayed requests.
- `DelayWidth`, 8: width of the per-request delay, in cycles.

Ports:
- `clk_i`  in  1: single clock.
- `rst_ni`  in  1: asynchronous, active-low reset.
- `req_valid_i`  in  1: new request present.
- `req_ready_o`  out  1: a free slot exists.
- `req_id_i`  in  IDWidth: ID of the new request.
- `req_delay_i`  in  DelayWidth: cycles to hold the request before release.
- `release_en_o`  out  2**IDWidth: bit i high means the oldest pending response of ID i may leave.
- `released_valid_i`  in  1: the bank completed an output handshake this cycle.
- `released_id_i`  in  IDWidth: ID of that handshake.

## Operation
- Per-slot state: `valid`, `id`, `counter[DelayWidth]`, `rank[$clog2(NumSlots)]` (position within its ID queue, 0 = oldest).
- Per-ID state: `outstanding[$clog2(NumSlots+1)]`.
- Allocation:
  - On `req_valid_i && req_ready_o`, the lowest-index free slot is set to valid, `id = req_id_i`, `counter = req_delay_i`.
  - `rank = outstanding[req_id_i]`, minus 1 if a release of the same ID occurs in the same cycle.
  - `outstanding[req_id_i]` increments.
- Countdown: every valid slot with `counter != 0` decrements by 1 each cycle. At 0 it holds (saturates); it never wraps.
- Release enable: `release_en_o[i] = OR over slots (valid && id==i && rank==0 && counter==0)`. This is combinational from registered state only.
- Release:
  - On `released_valid_i`, the slot with `id==released_id_i && rank==0` is freed.
  - Every other valid slot of that ID decrements its rank.
  - `outstanding` for that ID decrements.
- Simultaneous request and release, same ID: `outstanding` is unchanged.
- Simultaneous request and release, different IDs: both updates apply independently.
- Release for an ID with no matured rank-0 slot: ignored; a protocol violation.
- Full: `req_ready_o = |~valid` from registered state. A slot freed in cycle t is allocatable from cycle t+1; there is no same-cycle reuse.
- Empty: `release_en_o = '0`.

## Timing
- Reset values: all slots invalid, all `outstanding = 0`, `release_en_o = '0`, `req_ready_o = 1` (since `NumSlots > 0`).
- Latency: a request accepted at edge t with delay D asserts `release_en_o[id]` in cycle t+1+D, provided it is rank 0. D=0 asserts in cycle t+1.
- A younger request of the same ID is not enabled before the older one is released, even if its counter reaches 0 first. Its enable rises in the cycle after the older release.
- `release_en_o[i]` stays high until the release handshake for ID i. It drops in the following cycle unless the next-ranked slot has already matured, in which case it stays high without a gap.
- Reset asserted mid-operation clears all state asynchronously. In-flight delays are lost.

## Configuration
- `SIMMEM_RELEASE_ENABLER_ASSERT_EN`: when defined, SVA properties are compiled in:
  - no release without the matching enable;
  - `outstanding` never exceeds `NumSlots`;
  - at most one rank-0 slot per ID;
  - `req_valid_i` stable until ready.
- When undefined, the module contains no assertions and functional behaviour is identical.

## Structure
- `simmem_pkg` holds the `release_slot_t` struct (`valid`, `id`, `counter`, `rank`) and the localparams `SlotIdxWidth = $clog2(NumSlots)` and `NumIds = 2**IDWidth`.
- Sub-module `simmem_delay_slot` is one instance per slot. It holds the register, counter decrement, rank update, and matured output.
- The top level holds:
  - the lowest-free priority encoder;
  - the per-ID `outstanding` counters;
  - the ID-to-one-hot OR reduction producing `release_en_o`.

## Test plan
- Single request ID 3 with delay 4 accepted at cycle 10: `release_en_o[3]` rises in cycle 15 and falls the cycle after a release of ID 3.
- ID 5 with delay 10, then ID 5 with delay 0: bit 5 rises only at the first request's maturity. After its release, bit 5 stays high continuously for the second request.
- Fill all 16 slots with delay 255: `req_ready_o = 0`. Release one matured slot at cycle t: `req_ready_o` returns to 1 in cycle t+1.
- Same-cycle request and release on ID 7 with one outstanding: the new slot gets rank 0, `outstanding[7]` stays 1, and bit 7 follows the new slot's delay.
- Delay 0 on IDs 1 and 2 accepted on consecutive cycles: bits 1 and 2 assert independently; releasing ID 2 first leaves bit 1 high.
- Assert `rst_ni` low mid-countdown with 4 slots active: `release_en_o = 0` and `req_ready_o = 1` immediately; no stale enables after reset.
